// File: rtl/fsm_defs_pkg.sv
// Shared definitions for the start-triggered FSM blocks (counter and pulse measure).
// State encodings and default sizing constants live here so both sides agree.
package fsm_defs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } fsm_state_e;

    localparam int unsigned FSM_CNT_W   = 8;
    localparam int unsigned FSM_TIMEOUT = 200;

endpackage

// File: rtl/fsm_pulse_measure_rise_detect.sv
// Rising-edge detector: registers d every edge and flags d high while its last sample was low.
// The registered copy clears on reset, so a level held high through reset reads as a rise.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // NOTE: clocked state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/fsm_pulse_measure.sv
// Latency monitor: arms on start, counts edges to the next rising edge of in, strobes valid.
// Optional abandon-after-TIMEOUT behaviour is compiled in with `define MEAS_TIMEOUT_EN.
module fsm_pulse_measure
    import fsm_defs_pkg::*;
#(
    parameter int unsigned CNT_W   = FSM_CNT_W,
    parameter int unsigned TIMEOUT = FSM_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in,
    output logic             busy,
    output logic [CNT_W-1:0] meas,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

`ifdef MEAS_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic [CNT_W:0]   cnt_inc;
    logic [CNT_W-1:0] cnt_sat;
    logic             rise;
    logic             timeout_hit;

    rise_detect u_rise_detect (
        .clk  (clk),
        .rst  (rst),
        .d    (in),
        .rise (rise)
    );

    // One extra bit catches the carry so the count pins at all-ones instead of wrapping.
    assign cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign cnt_sat = cnt_inc[CNT_W] ? {CNT_W{1'b1}} : cnt_inc[CNT_W-1:0];

    // A rise on the limit edge wins, so the limit only fires when no rise is present.
    assign timeout_hit = TIMEOUT_EN && (state_q == COUNT) && (cnt_q == TO_LAST) && !rise;

    // NOTE: defaults first keep every path assigned, so no latches are inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        meas_d  = meas_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
            end
            COUNT: begin
                cnt_d = cnt_sat;
                if (rise) begin
                    state_d = DONE;
                    meas_d  = cnt_sat;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            meas_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
        end
    end

`ifdef MEAS_TIMEOUT_EN
    logic timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy  = (state_q == COUNT);
    assign valid = (state_q == DONE);
    assign meas  = meas_q;

endmodule

// File: tb/tb_fsm_pulse_measure.sv
// Bench for fsm_pulse_measure: 8-bit and 4-bit instances share stimulus and are checked
// every cycle against an edge-index reference model; honours MEAS_TIMEOUT_EN when defined.
module tb_fsm_pulse_measure;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       in_sig;
    logic       busy8, valid8, to8;
    logic [7:0] meas8;
    logic       busy4, valid4, to4;
    logic [3:0] meas4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: remembers the edge index at which start was taken and reports
    // the distance to the first rise, clamped to the result width.
    int k = 0;
    int m_t0 = 0;
    bit m_busy = 0;
    bit m_done = 0;
    bit m_in_prev = 0;
    bit exp_to = 0;
    int exp_meas8 = 0;
    int exp_meas4 = 0;
    bit in_v = 0;

    always #5 clk = ~clk;

    fsm_pulse_measure #(.CNT_W(8), .TIMEOUT(TO)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in(in_sig),
        .busy(busy8), .meas(meas8), .valid(valid8), .timeout(to8)
    );

    fsm_pulse_measure #(.CNT_W(4), .TIMEOUT(TO)) dut4 (
        .clk(clk), .rst(rst), .start(start), .in(in_sig),
        .busy(busy4), .meas(meas4), .valid(valid4), .timeout(to4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (n > lim) ? lim : n;
    endfunction

    task automatic model_reset();
        m_busy    = 0;
        m_done    = 0;
        m_in_prev = 0;
        exp_to    = 0;
        exp_meas8 = 0;
        exp_meas4 = 0;
    endtask

    task automatic model_edge(input bit s, input bit i);
        bit rise;
        int n;
        rise      = i && !m_in_prev;
        m_in_prev = i;
        exp_to    = 0;
        k++;
        if (m_done) begin
            m_done = 0;
        end else if (m_busy) begin
            n = k - m_t0;
            if (rise) begin
                m_busy    = 0;
                m_done    = 1;
                exp_meas8 = sat(n, 8);
                exp_meas4 = sat(n, 4);
            end
`ifdef MEAS_TIMEOUT_EN
            else if (n == TO) begin
                m_busy = 0;
                exp_to = 1;
            end
`endif
        end else if (s) begin
            m_busy = 1;
            m_t0   = k;
        end
    endtask

    task automatic compare_all();
        check("busy8",    busy8,  m_busy);
        check("valid8",   valid8, m_done);
        check("meas8",    meas8,  exp_meas8);
        check("timeout8", to8,    exp_to);
        check("busy4",    busy4,  m_busy);
        check("valid4",   valid4, m_done);
        check("meas4",    meas4,  exp_meas4);
        check("timeout4", to4,    exp_to);
    endtask

    // Drive at the falling edge, let the model see the rising edge, compare 1 ns later.
    task automatic step(input bit s, input bit i);
        @(negedge clk);
        start  = s;
        in_sig = i;
        in_v   = i;
        @(posedge clk);
        model_edge(s, i);
        #1;
        compare_all();
    endtask

    // Called 1 ns after a rising edge: pulses rst between edges and checks outputs while held.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        in_sig = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        #3;
        rst = 1'b0;

        step(0, 0);

        // Basic latency: start at t0, rise sampled at t0+5.
        step(1, 0);
        repeat (4) step(0, 0);
        step(0, 1);
        check("basic_meas", meas8, 5);
        check("basic_valid", valid8, 1);
        step(0, 1);
        check("basic_valid_drop", valid8, 0);

        // Level already high at arm time must fall and rise again.
        step(1, 1);
        step(0, 1);
        repeat (5) step(0, 0);
        step(0, 1);
        check("high_meas", meas8, 7);

        // Extra start during COUNT is ignored; held start re-arms two cycles after valid.
        step(0, 0);
        step(1, 0);
        step(0, 0);
        step(1, 0);
        repeat (3) step(0, 0);
        step(1, 1);
        check("rearm_meas", meas8, 6);
        step(1, 1);
        check("rearm_gap_busy", busy8, 0);
        step(1, 1);
        check("rearm_busy", busy8, 1);
        step(0, 0);
        step(0, 0);
        step(0, 1);
        check("rearm2_meas", meas8, 3);
        step(0, 0);

        // Rise exactly on the limit edge is a successful measurement.
        step(1, 0);
        repeat (9) step(0, 0);
        step(0, 1);
        check("edge10_meas", meas8, 10);
        check("edge10_valid", valid8, 1);
        check("edge10_to", to8, 0);
        step(0, 0);

`ifdef MEAS_TIMEOUT_EN
        // No rise: abandoned after edge t0+10, meas retained.
        step(1, 0);
        repeat (9) step(0, 0);
        step(0, 0);
        check("to_pulse", to8, 1);
        check("to_meas", meas8, 10);
        check("to_busy", busy8, 0);
        check("to_valid", valid8, 0);
        step(0, 0);
        check("to_drop", to8, 0);
`else
        // Narrow instance saturates, wide instance reports the true distance.
        step(1, 0);
        repeat (19) step(0, 0);
        step(0, 1);
        check("sat_meas4", meas4, 15);
        check("sat_valid4", valid4, 1);
        check("sat_meas8", meas8, 20);
        step(0, 0);
`endif

        // Reset mid-COUNT clears everything before the next edge; a following rise is ignored.
        step(1, 0);
        repeat (3) step(0, 0);
        async_reset();
        check("rst_meas", meas8, 0);
        check("rst_busy", busy8, 0);
        step(0, 1);
        step(0, 1);
        check("post_rst_valid", valid8, 0);

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            bit s;
            bit i;
            s = ($urandom_range(0, 7) == 0);
            i = in_v;
            if ($urandom_range(0, 5) == 0) i = ~i;
            step(s, i);
            if ($urandom_range(0, 399) == 0) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
